// File: rtl/console_detect_pkg.sv
// Shared types and helpers for the console-type detector.
// State encoding doubles as status[7:6].
package console_detect_pkg;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_PROBE   = 2'd1,
      ST_CLASSIC = 2'd2,
      ST_NEW     = 2'd3
   } cd_state_t;

   localparam int STATUS_W = 8;

   function automatic int cnt_w(input int p);
      return (p < 1) ? 1 : $clog2(p + 1);
   endfunction

   function automatic logic [4:0] sat5(input int unsigned v);
      return (v > 31) ? 5'd31 : v[4:0];
   endfunction

endpackage

// File: rtl/cd_sync2.sv
// Generic N-bit two-flop synchroniser with async active-high reset.
// RST_VAL selects the per-bit reset level (e.g. 1 for an idle-high strobe).
module cd_sync2 #(
   parameter int           N       = 1,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/console_detect.sv
// Power-on console-type detector: grounds CIRAM lines, then probes PPU reads.
// Define CONSOLE_DETECT_VOTE_EN for an up/down mismatch vote instead of a run count.
module console_detect
   import console_detect_pkg::*;
#(
   parameter int INIT_CYCLES        = 15,
   parameter int SAMPLES_PER_LEVEL  = 2,
   parameter int MISMATCH_THRESHOLD = 1,
   parameter int TIMEOUT_CYCLES     = 65535
) (
   input  logic                m2,
   input  logic                reset,
   input  logic                ppu_rd_in,
   input  logic                ppu_a13,
   input  logic                ppu_not_a13,
   output logic                ground_en,
   output logic                init_finished,
   output logic                detect_done,
   output logic                new_dendy,
   output logic [STATUS_W-1:0] status
);

   localparam int IW = cnt_w(INIT_CYCLES);
   localparam int LW = cnt_w(SAMPLES_PER_LEVEL);
   localparam int SW = cnt_w(MISMATCH_THRESHOLD);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);

   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
   localparam logic [LW-1:0] LVL_MAX   = LW'(SAMPLES_PER_LEVEL);
   localparam logic [SW-1:0] SC_MAX    = '1;
   localparam logic [SW-1:0] SC_THR    = SW'(MISMATCH_THRESHOLD);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0] sync_q;
   logic       rd_s;
   logic       a13_s;
   logic       na13_s;

   cd_sync2 #(
      .N       (3),
      .RST_VAL (3'b001)
   ) u_sync (
      .clk (m2),
      .rst (reset),
      .d   ({ppu_not_a13, ppu_a13, ppu_rd_in}),
      .q   (sync_q)
   );

   assign {na13_s, a13_s, rd_s} = sync_q;

   cd_state_t     state,    state_nx;
   logic [IW-1:0] init_cnt, init_nx;
   logic [LW-1:0] lvl_lo,   lo_nx;
   logic [LW-1:0] lvl_hi,   hi_nx;
   logic [SW-1:0] score,    score_nx;
   logic [TW-1:0] tmo_cnt,  tmo_nx;
   logic          tmo_hit,  tmo_hit_nx;

   logic smp_valid;
   logic lvl_done;

   assign smp_valid = ~rd_s;
   assign lvl_done  = (lvl_lo == LVL_MAX) && (lvl_hi == LVL_MAX);

   always_ff @(posedge m2 or posedge reset) begin
      if (reset) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         lvl_lo   <= '0;
         lvl_hi   <= '0;
         score    <= '0;
         tmo_cnt  <= '0;
         tmo_hit  <= 1'b0;
      end else begin
         state    <= state_nx;
         init_cnt <= init_nx;
         lvl_lo   <= lo_nx;
         lvl_hi   <= hi_nx;
         score    <= score_nx;
         tmo_cnt  <= tmo_nx;
         tmo_hit  <= tmo_hit_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      init_nx    = init_cnt;
      lo_nx      = lvl_lo;
      hi_nx      = lvl_hi;
      score_nx   = score;
      tmo_nx     = tmo_cnt;
      tmo_hit_nx = tmo_hit;
      unique case (state)
         ST_INIT: begin
            if (init_cnt == INIT_LAST)
               state_nx = ST_PROBE;
            else
               init_nx = init_cnt + IW'(1);
         end
         ST_PROBE: begin
            if (tmo_cnt != TMO_MAX)
               tmo_nx = tmo_cnt + TW'(1);
            if (smp_valid && !lvl_done) begin
               if (a13_s) begin
                  if (lvl_hi != LVL_MAX)
                     hi_nx = lvl_hi + LW'(1);
               end else if (lvl_lo != LVL_MAX) begin
                  lo_nx = lvl_lo + LW'(1);
               end
               // a13 equal to /a13 means the host is not driving them complementary
               if (a13_s == na13_s) begin
                  if (score != SC_MAX)
                     score_nx = score + SW'(1);
               end else begin
`ifdef CONSOLE_DETECT_VOTE_EN
                  if (score != '0)
                     score_nx = score - SW'(1);
`else
                  score_nx = '0;
`endif
               end
            end
            if (score_nx >= SC_THR) begin
               state_nx = ST_NEW;
            end else if (lo_nx == LVL_MAX && hi_nx == LVL_MAX) begin
               state_nx = ST_CLASSIC;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nx   = ST_CLASSIC;
               tmo_hit_nx = 1'b1;
            end
         end
         ST_CLASSIC, ST_NEW: begin
         end
      endcase
   end

   assign ground_en     = (state == ST_INIT);
   assign init_finished = (state != ST_INIT);
   assign detect_done   = (state == ST_CLASSIC) || (state == ST_NEW);
   assign new_dendy     = (state == ST_NEW);
   assign status        = {state, tmo_hit, sat5(32'(score))};

endmodule
